// File: rtl/dot_accumulator.sv
// Fixed-point multiply-accumulate engine: sums para_len signed operand products with
// saturation and presents the 32-bit result on a valid/ready port feeding the rounder.
module dot_accumulator #(
    parameter int para_int_bits  = 7,
    parameter int para_frac_bits = 9,
    parameter int para_len       = 8
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [para_int_bits+para_frac_bits-1:0]      in_a,
    input  logic [para_int_bits+para_frac_bits-1:0]      in_b,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [2*(para_int_bits+para_frac_bits)-1:0]  out_data,
    output logic                                         out_sat
);

    localparam int W  = para_int_bits + para_frac_bits;
    localparam int P  = 2 * W;
    localparam int CW = $clog2(para_len) + 1;

    localparam logic [CW-1:0] LAST_IDX = CW'(para_len - 1);
    localparam logic [P-1:0]  SAT_POS  = {1'b0, {(P-1){1'b1}}};
    localparam logic [P-1:0]  SAT_NEG  = {1'b1, {(P-1){1'b0}}};

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [P-1:0]    acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sat_q, sat_d;
    logic [P-1:0]    data_q, data_d;
    logic            osat_q, osat_d;

    logic signed [P-1:0] prod;
    logic [P:0]          sum;
    logic                ovf;
    logic [P-1:0]        clamped;
    logic                accept;

    // Operands are sign-extended to P bits first so the product is exact at full width.
    assign prod    = $signed({{W{in_a[W-1]}}, in_a}) * $signed({{W{in_b[W-1]}}, in_b});
    assign sum     = {acc_q[P-1], acc_q} + {prod[P-1], prod};
    assign ovf     = sum[P] ^ sum[P-1];
    assign clamped = ovf ? (sum[P] ? SAT_NEG : SAT_POS) : sum[P-1:0];

    assign in_ready  = (state_q == ACC) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == HOLD) && !rst;
    assign out_data  = rst ? '0 : data_q;
    assign out_sat   = osat_q && !rst;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        data_d  = data_q;
        osat_d  = osat_q;
        unique case (state_q)
            ACC: begin
                if (accept) begin
                    acc_d = clamped;
                    sat_d = sat_q | ovf;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = HOLD;
                        data_d  = clamped;
                        osat_d  = sat_q | ovf;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            data_q  <= '0;
            osat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            data_q  <= data_d;
            osat_q  <= osat_d;
        end
    end

endmodule
